// File: rtl/fp_mul_arb_pkg.sv
// Shared types and IEEE-754 single constants for the shared FP multiplier arbiter.
package fp_mul_arb_pkg;

  localparam int unsigned FP_W  = 32;
  localparam int unsigned CNT_W = 16;

  localparam logic [FP_W-1:0] QNAN    = 32'hFFC0_0000;
  localparam logic [FP_W-1:0] POS_INF = 32'h7F80_0000;
  localparam logic [FP_W-1:0] NEG_INF = 32'hFF80_0000;

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    WAIT_Z,
    ACK_Z,
    RESP
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request at or after ptr+1, modulo NREQ.
module rr_arbiter
  import fp_mul_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_idx
);

  logic [IDW-1:0] cand;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(ptr) + k) % NREQ);
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one FP multiplier among NREQ requesters: grants round-robin, sequences the
// a/b/z strobe-ack channels and returns the tagged product on a shared response port.
module fp_mul_arbiter
  import fp_mul_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*FP_W-1:0] req_a,
  input  logic [NREQ*FP_W-1:0] req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [FP_W-1:0]      rsp_data,
  output logic [IDW-1:0]       rsp_id,
  input  logic                 rsp_ready,
  output logic [FP_W-1:0]      mul_a,
  output logic [FP_W-1:0]      mul_b,
  output logic                 mul_a_stb,
  output logic                 mul_b_stb,
  input  logic                 mul_a_ack,
  input  logic                 mul_b_ack,
  input  logic [FP_W-1:0]      mul_z,
  input  logic                 mul_z_stb,
  output logic                 mul_z_ack,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  state_e            state_q;
  logic [IDW-1:0]    ptr_q;
  logic [IDW-1:0]    id_q;
  logic [NREQ-1:0]   req_ready_q;
  logic              rsp_valid_q;
  logic [FP_W-1:0]   rsp_data_q;
  logic [FP_W-1:0]   mul_a_q;
  logic [FP_W-1:0]   mul_b_q;
  logic              mul_a_stb_q;
  logic              mul_b_stb_q;
  logic              mul_z_ack_q;
  logic              busy_q;
  logic [CNT_W-1:0]  op_count_q;

  logic              gnt_valid;
  logic [IDW-1:0]    gnt_idx;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Sequencer: one operation in flight, every output driven from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(NREQ - 1);
      id_q        <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_a_stb_q <= 1'b0;
      mul_b_stb_q <= 1'b0;
      mul_z_ack_q <= 1'b0;
      busy_q      <= 1'b0;
      op_count_q  <= '0;
    end else begin
      req_ready_q <= '0;
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            req_ready_q <= NREQ'(1) << gnt_idx;
            mul_a_q     <= req_a[FP_W*gnt_idx +: FP_W];
            mul_b_q     <= req_b[FP_W*gnt_idx +: FP_W];
            id_q        <= gnt_idx;
            ptr_q       <= gnt_idx;
            mul_a_stb_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= SEND_A;
          end
        end
        SEND_A: begin
          if (mul_a_ack) begin
            mul_a_stb_q <= 1'b0;
            mul_b_stb_q <= 1'b1;
            state_q     <= SEND_B;
          end
        end
        SEND_B: begin
          if (mul_b_ack) begin
            mul_b_stb_q <= 1'b0;
            state_q     <= WAIT_Z;
          end
        end
        WAIT_Z: begin
          if (mul_z_stb) begin
            rsp_data_q  <= mul_z;
            mul_z_ack_q <= 1'b1;
            state_q     <= ACK_Z;
          end
        end
        // The multiplier still shows z_stb here; it is ignored on purpose.
        ACK_Z: begin
          mul_z_ack_q <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + CNT_W'(1);
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = id_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_a_stb = mul_a_stb_q;
  assign mul_b_stb = mul_b_stb_q;
  assign mul_z_ack = mul_z_ack_q;
  assign busy      = busy_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Scoreboard bench for fp_mul_arbiter with a behavioural strobe/ack multiplier model.
module tb_fp_mul_arbiter;
  import fp_mul_arb_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*32-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_ready;
  logic [31:0]       mul_a, mul_b, mul_z;
  logic              mul_a_stb, mul_b_stb, mul_a_ack, mul_b_ack, mul_z_stb, mul_z_ack;
  logic              busy;
  logic [15:0]       op_count;

  always #5 clk = ~clk;

  fp_mul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_a_stb(mul_a_stb),
    .mul_b_stb(mul_b_stb), .mul_a_ack(mul_a_ack), .mul_b_ack(mul_b_ack), .mul_z(mul_z),
    .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack), .busy(busy), .op_count(op_count)
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    data;
  } exp_t;

  int   vec = 0;
  int   errs = 0;
  exp_t sb[$];
  int   gnt_log[$];
  int   zack_lens[$];
  int   ready_bad, zack_run, a_cnt, b_cnt, z_cnt, exp_ops;
  int   a_hold = 1, b_hold = 1, z_lat = 2;
  logic [NREQ-1:0] ready_prev;
  bit   overlap_seen, z_acked;
  logic [31:0] la, lb;

  // Multiplier stand-in: known IEEE products, otherwise an arbitrary operand-order-sensitive mix.
  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h4000_0000, 32'h4040_0000}: return 32'h40C0_0000;
      {32'h3FC0_0000, 32'h3FC0_0000}: return 32'h4010_0000;
      {32'h3FC0_0000, 32'h4000_0000}: return 32'h4040_0000;
      {32'h4120_0000, 32'h4120_0000}: return 32'h42C8_0000;
      {32'h0000_0000, 32'h7F80_0000}: return QNAN;
      {32'hC000_0000, 32'h7F80_0000}: return NEG_INF;
      {32'h7F80_0000, 32'h3F80_0000}: return POS_INF;
      default: return a ^ {b[15:0], b[31:16]};
    endcase
  endfunction

  // One cycle: advance to the falling edge, run monitors, requester release and multiplier model.
  task automatic tick();
    @(negedge clk);
    if (mul_a_stb && mul_b_stb) overlap_seen = 1'b1;
    if (req_ready != '0) begin
      if ($countones(req_ready) != 1 || ready_prev != '0) ready_bad++;
      for (int i = 0; i < NREQ; i++)
        if (req_ready[i]) begin
          gnt_log.push_back(i);
          req_valid[i] = 1'b0;
        end
    end
    ready_prev = req_ready;
    if (mul_z_ack) zack_run++;
    else if (zack_run != 0) begin
      zack_lens.push_back(zack_run);
      zack_run = 0;
    end
    if (rst) begin
      mul_a_ack = 1'b0; mul_b_ack = 1'b0; mul_z_stb = 1'b0;
      a_cnt = 0; b_cnt = 0; z_cnt = 0; z_acked = 1'b0;
    end else begin
      if (a_cnt != 0) a_cnt--;
      else begin
        mul_a_ack = 1'b0;
        if (mul_a_stb) begin la = mul_a; mul_a_ack = 1'b1; a_cnt = a_hold - 1; end
      end
      if (b_cnt != 0) b_cnt--;
      else begin
        mul_b_ack = 1'b0;
        if (mul_b_stb) begin lb = mul_b; mul_b_ack = 1'b1; b_cnt = b_hold - 1; z_cnt = z_lat; end
      end
      if (mul_z_stb) begin
        if (mul_z_ack) z_acked = 1'b1;
        else if (z_acked) begin mul_z_stb = 1'b0; z_acked = 1'b0; end
      end else if (z_cnt != 0) begin
        z_cnt--;
        if (z_cnt == 0) begin mul_z = model_mul(la, lb); mul_z_stb = 1'b1; end
      end
    end
  endtask

  task automatic issue(input int r, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] z, input bit track);
    exp_t t;
    req_a[32*r +: 32] = a;
    req_b[32*r +: 32] = b;
    req_valid[r] = 1'b1;
    if (track) begin
      t.id = IDW'(r);
      t.data = z;
      sb.push_back(t);
    end
  endtask

  task automatic wait_rsp(output bit got);
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (rsp_valid) begin got = 1'b1; break; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    exp_ops = 0;
    gnt_log.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    tick(); tick();
    vec++;
    if ({req_ready, rsp_valid, mul_a_stb, mul_b_stb, mul_z_ack, busy} !== '0) begin
      errs++;
      $display("FAIL reset_ctrl: ready=%b rsp_valid=%b a_stb=%b b_stb=%b z_ack=%b busy=%b, required all 0",
               req_ready, rsp_valid, mul_a_stb, mul_b_stb, mul_z_ack, busy);
    end
    vec++;
    if (rsp_data !== 32'h0 || rsp_id !== '0 || mul_a !== 32'h0 || mul_b !== 32'h0 || op_count !== 16'h0) begin
      errs++;
      $display("FAIL reset_data: rsp_data=%h rsp_id=%0d mul_a=%h mul_b=%h op_count=%0d, required 0",
               rsp_data, rsp_id, mul_a, mul_b, op_count);
    end
    rst = 1'b0;
    tick();
    exp_ops = 0;
    vec++;
    if (busy !== 1'b0) begin errs++; $display("FAIL idle_busy: busy=%b, required 0", busy); end
  endtask

  task automatic test_single();
    bit got; exp_t e;
    gnt_log.delete(); ready_bad = 0;
    issue(1, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b1);
    tick();
    vec++;
    if (gnt_log.size() != 1 || gnt_log[0] != 1 || !mul_a_stb || mul_a !== 32'h4000_0000) begin
      errs++;
      $display("FAIL single_grant: grants=%0d first=%0d a_stb=%b mul_a=%h, required 1 grant to 1, a_stb=1, mul_a=40000000",
               gnt_log.size(), gnt_log.size() ? gnt_log[0] : -1, mul_a_stb, mul_a);
    end
    wait_rsp(got);
    vec++;
    if (!got) begin errs++; $display("FAIL single_rsp: timeout, got no rsp_valid, required one"); end
    else begin
      e = sb.pop_front();
      vec++;
      if (rsp_data !== e.data || rsp_id !== e.id) begin
        errs++;
        $display("FAIL single_rsp: id=%0d data=%h, required id=%0d data=%h", rsp_id, rsp_data, e.id, e.data);
      end
    end
    tick(); exp_ops++;
    vec++;
    if (op_count !== 16'(exp_ops) || busy !== 1'b0 || ready_bad != 0) begin
      errs++;
      $display("FAIL single_count: op_count=%0d busy=%b ready_bad=%0d, required %0d, 0, 0",
               op_count, busy, ready_bad, exp_ops);
    end
  endtask

  task automatic test_round_robin();
    bit got; bit ok; exp_t e;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [31:0] a, b;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      a = 32'h4000_0000 + 32'(i) * 32'h0010_0000;
      b = 32'h3F80_0000 + 32'(i);
      issue(i, a, b, model_mul(a, b), 1'b1);
    end
    for (int k = 0; k < 5; k++) begin
      wait_rsp(got);
      vec++;
      if (!got) begin errs++; $display("FAIL rr_rsp%0d: timeout, required a response", k); end
      else begin
        e = sb.pop_front();
        vec++;
        if (rsp_data !== e.data || rsp_id !== e.id) begin
          errs++;
          $display("FAIL rr_rsp%0d: id=%0d data=%h, required id=%0d data=%h", k, rsp_id, rsp_data, e.id, e.data);
        end
        exp_ops++;
      end
      if (k == 0) issue(0, 32'h4120_0000, 32'h4120_0000, 32'h42C8_0000, 1'b1);
    end
    ok = (gnt_log.size() == 5);
    for (int i = 0; i < 5 && ok; i++) if (gnt_log[i] != exp_order[i]) ok = 1'b0;
    vec++;
    if (!ok) begin
      errs++;
      $display("FAIL rr_order: %0d grants, first=%0d last=%0d, required order 0,1,2,3,0",
               gnt_log.size(), gnt_log.size() ? gnt_log[0] : -1, gnt_log.size() ? gnt_log[$] : -1);
    end
    tick();
    vec++;
    if (op_count !== 16'(exp_ops)) begin
      errs++; $display("FAIL rr_count: op_count=%0d, required %0d", op_count, exp_ops);
    end
  endtask

  task automatic test_rsp_hold();
    bit got; bit stable; int n0; exp_t e;
    rsp_ready = 1'b0;
    issue(2, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b1);
    wait_rsp(got);
    vec++;
    if (!got) begin errs++; $display("FAIL hold_rsp: timeout, required rsp_valid"); end
    issue(3, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b1);
    n0 = gnt_log.size();
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h4010_0000 || rsp_id !== 2'd2) stable = 1'b0;
    end
    vec++;
    if (!stable) begin
      errs++;
      $display("FAIL hold_stable: rsp_valid=%b data=%h id=%0d, required 1, 40100000, 2 for 20 cycles",
               rsp_valid, rsp_data, rsp_id);
    end
    vec++;
    if (gnt_log.size() != n0) begin
      errs++; $display("FAIL hold_nogrant: %0d grants while held, required 0", gnt_log.size() - n0);
    end
    e = sb.pop_front();
    vec++;
    if (rsp_data !== e.data || rsp_id !== e.id) begin
      errs++; $display("FAIL hold_data: id=%0d data=%h, required id=%0d data=%h", rsp_id, rsp_data, e.id, e.data);
    end
    exp_ops++;
    rsp_ready = 1'b1;
    wait_rsp(got);
    vec++;
    if (!got) begin errs++; $display("FAIL hold_next: timeout, required response from 3"); end
    else begin
      e = sb.pop_front(); exp_ops++;
      vec++;
      if (rsp_data !== e.data || rsp_id !== e.id) begin
        errs++; $display("FAIL hold_next: id=%0d data=%h, required id=%0d data=%h", rsp_id, rsp_data, e.id, e.data);
      end
    end
    tick();
    vec++;
    if (op_count !== 16'(exp_ops)) begin
      errs++; $display("FAIL hold_count: op_count=%0d, required %0d", op_count, exp_ops);
    end
  endtask

  task automatic test_special();
    bit got; bit ok; exp_t e;
    logic [31:0] va[3] = '{32'h0000_0000, 32'hC000_0000, 32'h7F80_0000};
    logic [31:0] vb[3] = '{32'h7F80_0000, 32'h7F80_0000, 32'h3F80_0000};
    logic [31:0] vz[3] = '{32'hFFC0_0000, 32'hFF80_0000, 32'h7F80_0000};
    zack_lens.delete();
    for (int k = 0; k < 3; k++) begin
      issue(k, va[k], vb[k], vz[k], 1'b1);
      wait_rsp(got);
      vec++;
      if (!got) begin errs++; $display("FAIL special%0d: timeout, required a response", k); end
      else begin
        e = sb.pop_front(); exp_ops++;
        vec++;
        if (rsp_data !== e.data || rsp_id !== e.id) begin
          errs++; $display("FAIL special%0d: id=%0d data=%h, required id=%0d data=%h", k, rsp_id, rsp_data, e.id, e.data);
        end
      end
    end
    ok = (zack_lens.size() == 3);
    foreach (zack_lens[i]) if (zack_lens[i] != 1) ok = 1'b0;
    vec++;
    if (!ok) begin
      errs++;
      $display("FAIL zack_width: %0d ack pulses, first width=%0d, required 3 pulses of 1 cycle",
               zack_lens.size(), zack_lens.size() ? zack_lens[0] : -1);
    end
  endtask

  task automatic test_reset_mid();
    bit got; bit reached; bit seen; exp_t e;
    z_lat = 12;
    gnt_log.delete();
    issue(3, 32'h3F80_0000, 32'h4000_0000, 32'h0, 1'b0);
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      tick();
      if (gnt_log.size() != 0 && busy && !mul_a_stb && !mul_b_stb && !mul_z_ack) reached = 1'b1;
    end
    vec++;
    if (!reached) begin errs++; $display("FAIL mid_reach: never reached WAIT_Z, required within 40 cycles"); end
    rst = 1'b1;
    tick();
    vec++;
    if ({busy, mul_a_stb, mul_b_stb, mul_z_ack, req_ready, rsp_valid} !== '0) begin
      errs++;
      $display("FAIL mid_reset: busy=%b a_stb=%b b_stb=%b z_ack=%b ready=%b rsp_valid=%b, required all 0",
               busy, mul_a_stb, mul_b_stb, mul_z_ack, req_ready, rsp_valid);
    end
    rst = 1'b0; exp_ops = 0; z_lat = 2;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); if (rsp_valid) seen = 1'b1; end
    vec++;
    if (seen) begin errs++; $display("FAIL mid_norsp: rsp_valid=1 after reset, required 0"); end
    issue(1, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b1);
    wait_rsp(got);
    vec++;
    if (!got) begin errs++; $display("FAIL mid_after: timeout, required a response"); end
    else begin
      e = sb.pop_front(); exp_ops++;
      vec++;
      if (rsp_data !== e.data || rsp_id !== e.id) begin
        errs++; $display("FAIL mid_after: id=%0d data=%h, required id=%0d data=%h", rsp_id, rsp_data, e.id, e.data);
      end
    end
    tick();
    vec++;
    if (op_count !== 16'(exp_ops)) begin
      errs++; $display("FAIL mid_count: op_count=%0d, required %0d", op_count, exp_ops);
    end
  endtask

  task automatic test_slow_ack();
    bit got; exp_t e;
    a_hold = 3; b_hold = 2; overlap_seen = 1'b0;
    issue(2, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 1'b1);
    wait_rsp(got);
    vec++;
    if (!got) begin errs++; $display("FAIL slow_rsp: timeout, required a response"); end
    else begin
      e = sb.pop_front(); exp_ops++;
      vec++;
      if (rsp_data !== e.data || rsp_id !== e.id) begin
        errs++; $display("FAIL slow_rsp: id=%0d data=%h, required id=%0d data=%h", rsp_id, rsp_data, e.id, e.data);
      end
    end
    vec++;
    if (overlap_seen) begin errs++; $display("FAIL slow_overlap: a_stb and b_stb high together, required never"); end
    a_hold = 1; b_hold = 1;
  endtask

  task automatic test_back_to_back();
    bit got; exp_t e; int r;
    logic [31:0] a, b;
    for (int k = 0; k < 6; k++) begin
      r = int'($urandom_range(0, NREQ - 1));
      a = $urandom; b = $urandom;
      issue(r, a, b, model_mul(a, b), 1'b1);
      wait_rsp(got);
      vec++;
      if (!got) begin errs++; $display("FAIL b2b%0d: timeout, required a response", k); end
      else begin
        e = sb.pop_front(); exp_ops++;
        vec++;
        if (rsp_data !== e.data || rsp_id !== e.id) begin
          errs++; $display("FAIL b2b%0d: id=%0d data=%h, required id=%0d data=%h", k, rsp_id, rsp_data, e.id, e.data);
        end
      end
    end
    tick();
    vec++;
    if (op_count !== 16'(exp_ops)) begin
      errs++; $display("FAIL b2b_count: op_count=%0d, required %0d", op_count, exp_ops);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    mul_a_ack = 1'b0; mul_b_ack = 1'b0; mul_z_stb = 1'b0; mul_z = '0;
    ready_bad = 0; zack_run = 0; a_cnt = 0; b_cnt = 0; z_cnt = 0; exp_ops = 0;
    ready_prev = '0; overlap_seen = 1'b0; z_acked = 1'b0; la = '0; lb = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_rsp_hold();
    test_special();
    test_reset_mid();
    test_slow_ack();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
